// File: rtl/nettype_pkg.sv
// Shared types and constant text for the net-type directive emitter.
package nettype_pkg;

    typedef enum logic [3:0] {
        NT_WIRE   = 4'd0,
        NT_TRI    = 4'd1,
        NT_TRI0   = 4'd2,
        NT_TRI1   = 4'd3,
        NT_WAND   = 4'd4,
        NT_TRIAND = 4'd5,
        NT_WOR    = 4'd6,
        NT_TRIOR  = 4'd7,
        NT_TRIREG = 4'd8,
        NT_UWIRE  = 4'd9,
        NT_NONE   = 4'd10
    } nettype_e;

    localparam logic [3:0] NETTYPE_LAST = 4'd10;

    // Codes 2 and 3 are reserved and rejected.
    typedef enum logic [1:0] {
        OP_DEFAULT_NETTYPE = 2'd0,
        OP_RESETALL        = 2'd1
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFIX,
        S_NAME,
        S_CR,
        S_LF,
        S_RA
    } state_e;

    localparam int PREFIX_LEN = 17;
    localparam int RA_LEN     = 9;

    // 8'h60 is the grave accent that opens both directives.
    localparam logic [8*PREFIX_LEN-1:0] PREFIX_STR = {8'h60, "default_nettype "};
    localparam logic [8*RA_LEN-1:0]     RA_STR     = {8'h60, "resetall"};

    function automatic logic [7:0] prefix_char(input logic [4:0] idx);
        prefix_char = 8'h00;
        if (int'(idx) < PREFIX_LEN)
            prefix_char = PREFIX_STR[8*(PREFIX_LEN-1-int'(idx)) +: 8];
    endfunction

    function automatic logic [7:0] ra_char(input logic [4:0] idx);
        ra_char = 8'h00;
        if (int'(idx) < RA_LEN)
            ra_char = RA_STR[8*(RA_LEN-1-int'(idx)) +: 8];
    endfunction

endpackage

// File: rtl/nettype_name_rom.sv
// Combinational net-type name table: (code, idx) -> character and name length.
module nettype_name_rom
    import nettype_pkg::*;
(
    input  logic [3:0] i_code,
    input  logic [4:0] i_idx,
    output logic [7:0] o_char,
    output logic [2:0] o_len
);

    logic [47:0] w_name;

    // Length depends only on the code, so callers may feed an index derived from it.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_name = '0;
        o_len  = 3'd0;
        case (i_code)
            NT_WIRE:   begin w_name = "wire  "; o_len = 3'd4; end
            NT_TRI:    begin w_name = "tri   "; o_len = 3'd3; end
            NT_TRI0:   begin w_name = "tri0  "; o_len = 3'd4; end
            NT_TRI1:   begin w_name = "tri1  "; o_len = 3'd4; end
            NT_WAND:   begin w_name = "wand  "; o_len = 3'd4; end
            NT_TRIAND: begin w_name = "triand"; o_len = 3'd6; end
            NT_WOR:    begin w_name = "wor   "; o_len = 3'd3; end
            NT_TRIOR:  begin w_name = "trior "; o_len = 3'd5; end
            NT_TRIREG: begin w_name = "trireg"; o_len = 3'd6; end
            NT_UWIRE:  begin w_name = "uwire "; o_len = 3'd5; end
            NT_NONE:   begin w_name = "none  "; o_len = 3'd4; end
            default:   begin w_name = '0;       o_len = 3'd0; end
        endcase
    end

    always_comb begin
        o_char = 8'h00;
        if (i_idx < {2'b00, o_len})
            o_char = w_name[8*(5-int'(i_idx)) +: 8];
    end

endmodule

// File: rtl/nettype_directive_tx.sv
// Serialises default-net-type / resetall directive commands as ASCII lines on a
// byte stream and tracks the current default net type.
module nettype_directive_tx
    import nettype_pkg::*;
#(
    parameter bit EOL_CRLF       = 1'b0,
    parameter bit SKIP_REDUNDANT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_type,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       err,
    output logic [3:0] cur_type
);

    localparam state_e EOL_FIRST = EOL_CRLF ? S_CR : S_LF;

    state_e     r_state, w_nxt_state;
    logic [4:0] r_idx, w_nxt_idx;
    logic [7:0] r_data, w_nxt_data;
    logic       r_last, w_nxt_last;
    logic [3:0] r_cur_type;
    logic       r_err;

    logic       w_accept, w_hs, w_type_ok, w_reject, w_skip;
    logic [7:0] w_rom_char;
    logic [2:0] w_rom_len;

    assign cmd_ready = (r_state == S_IDLE);
    assign out_valid = (r_state != S_IDLE);
    assign out_data  = r_data;
    assign out_last  = r_last;
    assign err       = r_err;
    assign cur_type  = r_cur_type;

    assign w_accept  = cmd_valid && cmd_ready;
    assign w_hs      = out_valid && out_ready;
    assign w_type_ok = (cmd_type <= NETTYPE_LAST);
    assign w_reject  = (cmd_op == OP_DEFAULT_NETTYPE) ? !w_type_ok : (cmd_op != OP_RESETALL);
    assign w_skip    = SKIP_REDUNDANT && (cmd_op == OP_DEFAULT_NETTYPE)
                       && w_type_ok && (cmd_type == r_cur_type);

    // The name is always that of the current type: it was latched at acceptance.
    nettype_name_rom u_rom (
        .i_code (r_cur_type),
        .i_idx  (w_nxt_idx),
        .o_char (w_rom_char),
        .o_len  (w_rom_len)
    );

    // NOTE: async active-low reset, and sequential state is only ever written with <=.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_idx   <= w_nxt_idx;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && !w_reject && !w_skip)
                          w_nxt_state = (cmd_op == OP_RESETALL) ? S_RA : S_PREFIX;
            S_PREFIX: if (w_hs && r_idx == 5'(PREFIX_LEN-1)) w_nxt_state = S_NAME;
            S_NAME:   if (w_hs && r_idx == {2'b00, w_rom_len - 3'd1}) w_nxt_state = EOL_FIRST;
            S_RA:     if (w_hs && r_idx == 5'(RA_LEN-1)) w_nxt_state = EOL_FIRST;
            S_CR:     if (w_hs) w_nxt_state = S_LF;
            S_LF:     if (w_hs) w_nxt_state = S_IDLE;
            default:  w_nxt_state = S_IDLE;
        endcase

        if (w_nxt_state != r_state)
            w_nxt_idx = '0;
        else if (w_hs)
            w_nxt_idx = r_idx + 5'd1;
        else
            w_nxt_idx = r_idx;
    end

    // Next byte follows the next state, so a stalled beat recomputes the same value.
    always_comb begin
        w_nxt_data = 8'h00;
        w_nxt_last = 1'b0;
        case (w_nxt_state)
            S_PREFIX: w_nxt_data = prefix_char(w_nxt_idx);
            S_NAME:   w_nxt_data = w_rom_char;
            S_RA:     w_nxt_data = ra_char(w_nxt_idx);
            S_CR:     w_nxt_data = 8'h0D;
            S_LF:     begin w_nxt_data = 8'h0A; w_nxt_last = 1'b1; end
            default:  w_nxt_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data     <= 8'h00;
            r_last     <= 1'b0;
            r_err      <= 1'b0;
            r_cur_type <= NT_WIRE;
        end else begin
            r_data <= w_nxt_data;
            r_last <= w_nxt_last;
            r_err  <= w_accept && w_reject;
            if (w_accept && !w_reject)
                r_cur_type <= (cmd_op == OP_RESETALL) ? NT_WIRE : cmd_type;
        end
    end

endmodule
